// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// The burst FSM type is only used when ARB_BURST_EN is defined.
package fifo_arb_pkg;

  typedef enum logic {ARB, LOCK} arb_state_e;

  localparam int MAX_REQ            = 8;
  localparam int BURST_LEN_DEFAULT  = 4;
  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int DEFAULT_DATA_WIDTH = 16;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake bundle plus FIFO write-side signals.
// slave = arbiter view, master = producers/FIFO/bench view.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_almostfull;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic [ID_WIDTH-1:0]           grant_id;

  modport slave (
    input  req_valid, req_data, fifo_full, fifo_almostfull,
    output req_ready, fifo_wr_en, fifo_data_in, grant_id
  );

  modport master (
    output req_valid, req_data, fifo_full, fifo_almostfull,
    input  req_ready, fifo_wr_en, fifo_data_in, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter_picker.sv
// Combinational round-robin picker: first set request at or after
// (i_rr_ptr+1) mod NUM_REQ wins.
module rr_priority_picker #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [ID_WIDTH-1:0] i_rr_ptr,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [ID_WIDTH-1:0] o_idx,
  output logic                o_any
);

  always_comb begin
    int j;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    j       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(i_rr_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[j]) begin
        o_any      = 1'b1;
        o_idx      = ID_WIDTH'(j);
        o_grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter in front of a synchronous FIFO write port.
// Optional burst locking enabled by defining ARB_BURST_EN.
//   state | meaning
//   ARB   | free round-robin arbitration on every beat
//   LOCK  | only the requester in r_rr_ptr may be granted (burst)
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
`ifdef ARB_BURST_EN
  ,
  parameter int BURST_LEN  = BURST_LEN_DEFAULT
`endif
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);

  logic                  w_can_issue;
  logic [NUM_REQ-1:0]    w_req_mask;
  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_WIDTH-1:0]   w_idx;
  logic                  w_any;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_sel_data;

  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ID_WIDTH-1:0]   r_gid;
  logic [ID_WIDTH-1:0]   r_rr_ptr;

  // The in-flight write will consume the last free entry, so hold off.
  assign w_can_issue = !bus.fifo_full && !(r_wr_en && bus.fifo_almostfull);

`ifdef ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  arb_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_beat_cnt, w_cnt_nxt;

  assign w_req_mask = (r_state == LOCK)
                    ? (bus.req_valid & (NUM_REQ'(1) << r_rr_ptr))
                    : bus.req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_beat_cnt;
    case (r_state)
      ARB: begin
        if (w_xfer && (BURST_LEN > 1)) begin
          w_state_nxt = LOCK;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      LOCK: begin
        if (w_can_issue && !bus.req_valid[r_rr_ptr]) begin
          w_state_nxt = ARB;
          w_cnt_nxt   = '0;
        end else if (w_xfer) begin
          if (r_beat_cnt == CNT_W'(BURST_LEN - 1)) begin
            w_state_nxt = ARB;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_beat_cnt + CNT_W'(1);
          end
        end
      end
    endcase
  end
`else
  assign w_req_mask = bus.req_valid;
`endif

  rr_priority_picker #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .i_req    (w_req_mask),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_grant),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  assign w_xfer        = w_any && w_can_issue && !rst;
  assign bus.req_ready = w_xfer ? w_grant : '0;

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en  <= 1'b0;
      r_data   <= '0;
      r_gid    <= '0;
      r_rr_ptr <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      r_wr_en <= w_xfer;
      if (w_xfer) begin
        r_data   <= w_sel_data;
        r_gid    <= w_idx;
        r_rr_ptr <= w_idx;
      end
    end
  end

  assign bus.fifo_wr_en   = r_wr_en;
  assign bus.fifo_data_in = r_data;
  assign bus.grant_id     = r_gid;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with an output-beat scoreboard.
// Expectations follow the ARB_BURST_EN setting of the build.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  typedef struct packed {
    logic          we;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t         sb[$];
  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [DW-1:0] base[NR];
  int unsigned   cnt[NR];
  logic [IW-1:0] hold_id;
  logic [DW-1:0] hold_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check ready before the edge, check outputs after it.
  task automatic step(input logic r, input logic [NR-1:0] v, input logic f,
                      input logic af, input logic [NR-1:0] exp_rdy, input string tag);
    beat_t e;
    beat_t o;
    e = '0;
    rst = r;
    bus.req_valid = v;
    bus.fifo_full = f;
    bus.fifo_almostfull = af;
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = base[i] + DW'(cnt[i]);
    #4;
    check({tag, " ready"}, 32'(bus.req_ready), 32'(exp_rdy));
    if (r) begin
      hold_id = '0;
      hold_data = '0;
      e = '0;
    end else if (exp_rdy != '0) begin
      for (int i = 0; i < NR; i++) begin
        if (exp_rdy[i]) begin
          hold_id = IW'(i);
          hold_data = base[i] + DW'(cnt[i]);
          cnt[i]++;
        end
      end
      e = {1'b1, hold_id, hold_data};
    end else begin
      e = {1'b0, hold_id, hold_data};
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = {bus.fifo_wr_en, bus.grant_id, bus.fifo_data_in};
    e = sb.pop_front();
    check({tag, " wr_en"}, 32'(o.we), 32'(e.we));
    check({tag, " grant_id"}, 32'(o.id), 32'(e.id));
    check({tag, " data"}, 32'(o.data), 32'(e.data));
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int id;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.fifo_full = 1'b0;
    bus.fifo_almostfull = 1'b0;
    for (int i = 0; i < NR; i++) begin
      base[i] = 16'hA000 + DW'(i * 16'h0100);
      cnt[i] = 0;
    end
    hold_id = '0;
    hold_data = '0;
    @(negedge clk);

    // 1: reset, then all four valid
    step(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, "rst0");
    step(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, "rst1");
    for (int k = 0; k < 5; k++) begin
`ifdef ARB_BURST_EN
      id = (k < 4) ? 0 : 1;
`else
      id = k % 4;
`endif
      step(1'b0, 4'b1111, 1'b0, 1'b0, 4'(1 << id), "all_valid");
    end
    idle("idle1");

    // 2: lone requester 2, data 0x1000+n
    base[2] = 16'h1000;
    cnt[2] = 0;
    for (int k = 0; k < 8; k++) step(1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, "req2_only");
    idle("idle2");

    // 3: full stall with req1/req3, pointer parked on req0
    step(1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, "park0");
    idle("idle3a");
    for (int k = 0; k < 5; k++) step(1'b0, 4'b1010, 1'b1, 1'b0, 4'b0000, "full_stall");
    step(1'b0, 4'b1010, 1'b0, 1'b0, 4'b0010, "resume_req1");
`ifdef ARB_BURST_EN
    step(1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000, "unlock");
`endif
    step(1'b0, 4'b1000, 1'b0, 1'b0, 4'b1000, "then_req3");
    idle("idle3b");

    // 4: almost-full with a write in flight
    step(1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, "af_prime");
    step(1'b0, 4'b0001, 1'b0, 1'b1, 4'b0000, "af_inflight");
    step(1'b0, 4'b0001, 1'b0, 1'b1, 4'b0001, "af_one_grant");
    step(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, "af_then_full");
    idle("idle4");

    // 5: req0+req1 continuously valid, pointer parked on req1
    step(1'b0, 4'b0010, 1'b0, 1'b0, 4'b0010, "park1");
    idle("idle5");
    for (int k = 0; k < 8; k++) begin
`ifdef ARB_BURST_EN
      id = k / 4;
`else
      id = k % 2;
`endif
      step(1'b0, 4'b0011, 1'b0, 1'b0, 4'(1 << id), "pair");
    end

    // 6: reset pulse under full traffic
    step(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0100, "pre_rst");
    step(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, "mid_rst");
    step(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0001, "post_rst");
    idle("idle6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
